noc_port_arbiter: RTL and testbench

- Round-robin arbiter for one output port of a mesh router.
- Shares the port between three requesters: left link, bottom link and the local PE.
- Each requester presents a flit with a valid/ready handshake. The granted flit is registered into a one-entry output stage that holds under downstream backpressure.
- Replaces the fixed-priority casex selection in the router's output paths, so no input is silently dropped or starved.

---
 rtl/noc_port_arbiter.sv | 129 ++++++++++++
 tb/tb_noc_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter sharing one router output port between left, bottom and PE links.
// Define NOC_ARB_AGE_EN to let requesters that have waited MAX_WAIT cycles override round-robin.
module noc_port_arbiter #(
    parameter int data_width  = 8,
    parameter int x_size      = 2,
    parameter int y_size      = 2,
    parameter int total_width = 2*x_size + 2*y_size + data_width,
    parameter int MAX_WAIT    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid_l,
    input  logic                   i_valid_b,
    input  logic                   i_valid_pe,
    input  logic [total_width-1:0] i_data_l,
    input  logic [total_width-1:0] i_data_b,
    input  logic [total_width-1:0] i_data_pe,
    output logic                   o_ready_l,
    output logic                   o_ready_b,
    output logic                   o_ready_pe,
    output logic                   o_valid,
    output logic [total_width-1:0] o_data,
    input  logic                   i_ready,
    output logic [2:0]             o_grant,
    output logic                   o_busy
);

    typedef enum logic [1:0] {
        PTR_L  = 2'd0,
        PTR_B  = 2'd1,
        PTR_PE = 2'd2
    } ptr_t;

    ptr_t       ptr_q, ptr_d;
    logic [2:0] req;
    logic [2:0] pick;
    logic [2:0] grant;
    logic       can_accept;

    // Bit order of every vector here is {pe, b, l}; the scan starts at the pointer.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input ptr_t p);
        logic [2:0] g;
        g = 3'b000;
        case (p)
            PTR_B: begin
                if (r[1])      g = 3'b010;
                else if (r[2]) g = 3'b100;
                else if (r[0]) g = 3'b001;
            end
            PTR_PE: begin
                if (r[2])      g = 3'b100;
                else if (r[0]) g = 3'b001;
                else if (r[1]) g = 3'b010;
            end
            default: begin
                if (r[0])      g = 3'b001;
                else if (r[1]) g = 3'b010;
                else if (r[2]) g = 3'b100;
            end
        endcase
        return g;
    endfunction

    assign req        = {i_valid_pe, i_valid_b, i_valid_l};
    assign can_accept = ~o_valid | i_ready;

`ifdef NOC_ARB_AGE_EN
    localparam int AW = $clog2(MAX_WAIT + 1);

    logic [AW-1:0] wait_q [3];
    logic [2:0]    aged;

    for (genvar i = 0; i < 3; i++) begin : g_age
        assign aged[i] = req[i] && (wait_q[i] == AW'(MAX_WAIT));

        // Counts cycles spent waiting; any transfer or a dropped request restarts it.
        always_ff @(posedge clk) begin
            if (rst) begin
                wait_q[i] <= '0;
            end else if (req[i] && !grant[i]) begin
                if (wait_q[i] != AW'(MAX_WAIT)) begin
                    wait_q[i] <= wait_q[i] + 1'b1;
                end
            end else begin
                wait_q[i] <= '0;
            end
        end
    end

    assign pick = (|aged) ? rr_pick(aged, ptr_q) : rr_pick(req, ptr_q);
`else
    logic unused_max_wait;
    assign unused_max_wait = ^MAX_WAIT;
    assign pick = rr_pick(req, ptr_q);
`endif

    assign grant      = (can_accept && !rst) ? pick : 3'b000;
    assign o_ready_l  = grant[0];
    assign o_ready_b  = grant[1];
    assign o_ready_pe = grant[2];
    assign o_busy     = o_valid & ~i_ready;

    always_comb begin
        ptr_d = ptr_q;
        if (grant[0])      ptr_d = PTR_B;
        else if (grant[1]) ptr_d = PTR_PE;
        else if (grant[2]) ptr_d = PTR_L;
    end

    // A new grant refills the stage even while it drains, giving one flit per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= PTR_L;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_grant <= 3'b000;
        end else begin
            ptr_q <= ptr_d;
            if (|grant) begin
                o_valid <= 1'b1;
                o_grant <= grant;
                o_data  <= grant[0] ? i_data_l : (grant[1] ? i_data_b : i_data_pe);
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Randomised self-checking bench for noc_port_arbiter against a queue-free behavioural model.
// Honours NOC_ARB_AGE_EN in the model so either build can be checked.
module tb_noc_port_arbiter;

    localparam int TW       = 16;
    localparam int MAX_WAIT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    vin;
    logic [TW-1:0] din [3];
    logic          i_ready;
    logic          o_ready_l, o_ready_b, o_ready_pe;
    logic          o_valid, o_busy;
    logic [TW-1:0] o_data;
    logic [2:0]    o_grant;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int            m_ptr = 0;
    logic          m_valid = 1'b0;
    logic [TW-1:0] m_data = '0;
    logic [2:0]    m_grant = 3'b000;
    int            m_cnt [3] = '{0, 0, 0};
    logic [2:0]    exp_ready;
    logic          exp_busy;

    noc_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .i_valid_l(vin[0]), .i_valid_b(vin[1]), .i_valid_pe(vin[2]),
        .i_data_l(din[0]), .i_data_b(din[1]), .i_data_pe(din[2]),
        .o_ready_l(o_ready_l), .o_ready_b(o_ready_b), .o_ready_pe(o_ready_pe),
        .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
        .o_grant(o_grant), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model_pick(input logic r, input logic [2:0] v, input logic ir);
        logic [2:0] cand;
        logic [2:0] aged;
        int idx;
        if (r || (m_valid && !ir)) return 3'b000;
        cand = v;
        aged = 3'b000;
`ifdef NOC_ARB_AGE_EN
        for (int i = 0; i < 3; i++) if (v[i] && m_cnt[i] == MAX_WAIT) aged[i] = 1'b1;
`endif
        if (aged != 3'b000) cand = aged;
        for (int k = 0; k < 3; k++) begin
            idx = (m_ptr + k) % 3;
            if (cand[idx]) return 3'(1 << idx);
        end
        return 3'b000;
    endfunction

    task automatic drive(input logic r, input logic [2:0] v, input logic [TW-1:0] dl,
                         input logic [TW-1:0] db, input logic [TW-1:0] dpe, input logic ir);
        rst = r; vin = v; din[0] = dl; din[1] = db; din[2] = dpe; i_ready = ir;
        exp_ready = model_pick(r, v, ir);
        exp_busy  = m_valid && !ir;
        #1;
    endtask

    task automatic tick();
        int w;
        @(posedge clk);
        w = -1;
        for (int i = 0; i < 3; i++) if (exp_ready[i]) w = i;
        if (rst) begin
            m_ptr = 0; m_valid = 1'b0; m_data = '0; m_grant = 3'b000;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 3; i++)
                m_cnt[i] = (vin[i] && !exp_ready[i]) ? ((m_cnt[i] < MAX_WAIT) ? m_cnt[i] + 1 : MAX_WAIT) : 0;
            if (w >= 0) begin
                m_valid = 1'b1; m_data = din[w]; m_grant = 3'(1 << w); m_ptr = (w + 1) % 3;
            end else if (m_valid && i_ready) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b1, 3'b000, '0, '0, '0, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 3'b111, 16'h0011, 16'h0022, 16'h0033, 1'b1);
            n_cmp++;
            if ({o_ready_pe, o_ready_b, o_ready_l} !== 3'b000) begin
                n_fail++; $display("[TB] FAIL reset_ready: got %b want 000", {o_ready_pe, o_ready_b, o_ready_l});
            end
            tick();
            n_cmp++;
            if ({o_valid, o_grant, o_data} !== {1'b0, 3'b000, 16'h0000}) begin
                n_fail++; $display("[TB] FAIL reset_state: got v=%b g=%b d=%h want 0/000/0000", o_valid, o_grant, o_data);
            end
        end
        drive(1'b0, 3'b111, 16'h0011, 16'h0022, 16'h0033, 1'b1);
        n_cmp++;
        if ({o_ready_pe, o_ready_b, o_ready_l} !== 3'b001 || exp_ready !== 3'b001) begin
            n_fail++; $display("[TB] FAIL reset_first_grant: got %b want 001", {o_ready_pe, o_ready_b, o_ready_l});
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [TW-1:0] seq [4] = '{16'h0101, 16'h0202, 16'h0303, 16'h0101};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 3'b111, 16'h0101, 16'h0202, 16'h0303, 1'b1);
            n_cmp++;
            if ({o_ready_pe, o_ready_b, o_ready_l} !== exp_ready) begin
                n_fail++; $display("[TB] FAIL rr_ready[%0d]: got %b want %b", c, {o_ready_pe, o_ready_b, o_ready_l}, exp_ready);
            end
            tick();
            n_cmp++;
            if (o_valid !== 1'b1 || o_data !== seq[c] || o_grant !== m_grant || m_data !== seq[c]) begin
                n_fail++; $display("[TB] FAIL rr_out[%0d]: got d=%h g=%b want d=%h g=%b", c, o_data, o_grant, seq[c], m_grant);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b0, 3'b001, 16'h00A5, 16'h0000, 16'h0000, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 3'b010, 16'h0000, 16'h00B6, 16'h0000, 1'b0);
            n_cmp++;
            if ({o_ready_pe, o_ready_b, o_ready_l} !== 3'b000 || o_busy !== 1'b1) begin
                n_fail++; $display("[TB] FAIL bp_stall[%0d]: got rdy=%b busy=%b want 000/1", c, {o_ready_pe, o_ready_b, o_ready_l}, o_busy);
            end
            tick();
            n_cmp++;
            if (o_valid !== 1'b1 || o_data !== 16'h00A5) begin
                n_fail++; $display("[TB] FAIL bp_hold[%0d]: got v=%b d=%h want 1/00a5", c, o_valid, o_data);
            end
        end
        drive(1'b0, 3'b010, 16'h0000, 16'h00B6, 16'h0000, 1'b1);
        n_cmp++;
        if ({o_ready_pe, o_ready_b, o_ready_l} !== 3'b010 || o_busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL bp_passthru: got rdy=%b busy=%b want 010/0", {o_ready_pe, o_ready_b, o_ready_l}, o_busy);
        end
        tick();
        n_cmp++;
        if (o_valid !== 1'b1 || o_data !== 16'h00B6 || o_grant !== 3'b010) begin
            n_fail++; $display("[TB] FAIL bp_refill: got v=%b d=%h g=%b want 1/00b6/010", o_valid, o_data, o_grant);
        end
    endtask

    task automatic test_single_requester();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 3'b100, 16'h0000, 16'h0000, 16'(16'h0400 + c), 1'b1);
            tick();
            n_cmp++;
            if (o_grant !== 3'b100 || o_data !== 16'(16'h0400 + c)) begin
                n_fail++; $display("[TB] FAIL single_pe[%0d]: got g=%b d=%h want 100/%h", c, o_grant, o_data, 16'(16'h0400 + c));
            end
        end
        drive(1'b0, 3'b011, 16'h0111, 16'h0222, 16'h0000, 1'b1);
        n_cmp++;
        if ({o_ready_pe, o_ready_b, o_ready_l} !== 3'b001) begin
            n_fail++; $display("[TB] FAIL single_then_lb: got %b want 001", {o_ready_pe, o_ready_b, o_ready_l});
        end
        tick();
    endtask

    task automatic test_idle_drain();
        do_reset();
        drive(1'b0, 3'b010, 16'h0000, 16'h05A5, 16'h0000, 1'b1);
        tick();
        drive(1'b0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        tick();
        n_cmp++;
        if (o_valid !== 1'b0 || o_data !== 16'h05A5 || o_grant !== 3'b010) begin
            n_fail++; $display("[TB] FAIL idle_drain: got v=%b d=%h g=%b want 0/05a5/010", o_valid, o_data, o_grant);
        end
    endtask

    task automatic test_age();
        logic [2:0] pat [6] = '{3'b011, 3'b101, 3'b011, 3'b101, 3'b111, 3'b011};
        do_reset();
        drive(1'b0, 3'b001, 16'h0C01, 16'h0000, 16'h0000, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 3'b001, 16'h0C02, 16'h0000, 16'h0000, 1'b0);
            tick();
        end
        drive(1'b0, 3'b011, 16'h0C02, 16'h0B02, 16'h0000, 1'b1);
        n_cmp++;
        if ({o_ready_pe, o_ready_b, o_ready_l} !== exp_ready) begin
            n_fail++; $display("[TB] FAIL age_after_stall: got %b want %b", {o_ready_pe, o_ready_b, o_ready_l}, exp_ready);
        end
        tick();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, pat[c], 16'(16'h0C10 + c), 16'(16'h0B10 + c), 16'(16'h0E10 + c), 1'b1);
            n_cmp++;
            if ({o_ready_pe, o_ready_b, o_ready_l} !== exp_ready) begin
                n_fail++; $display("[TB] FAIL age_pulse[%0d]: got %b want %b", c, {o_ready_pe, o_ready_b, o_ready_l}, exp_ready);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [2:0]    rv;
        logic [TW-1:0] rd [3];
        logic          r;
        rv = 3'b000;
        rd = '{default: '0};
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!rv[i]) begin
                    rv[i] = 1'($urandom_range(0, 1));
                    rd[i] = 16'($urandom);
                end
            end
            r = ($urandom_range(0, 59) == 0);
            drive(r, rv, rd[0], rd[1], rd[2], $urandom_range(0, 3) != 0);
            n_cmp++;
            if ({o_ready_pe, o_ready_b, o_ready_l} !== exp_ready || o_busy !== exp_busy) begin
                n_fail++; $display("[TB] FAIL rand_comb[%0d]: got rdy=%b busy=%b want %b/%b", c, {o_ready_pe, o_ready_b, o_ready_l}, o_busy, exp_ready, exp_busy);
            end
            tick();
            n_cmp++;
            if (o_valid !== m_valid || o_data !== m_data || o_grant !== m_grant) begin
                n_fail++; $display("[TB] FAIL rand_out[%0d]: got v=%b d=%h g=%b want %b/%h/%b", c, o_valid, o_data, o_grant, m_valid, m_data, m_grant);
            end
            rv = rv & ~exp_ready;
            if (r) rv = 3'b000;
        end
    endtask

    initial begin
        rst = 1'b1; vin = 3'b000; din = '{default: '0}; i_ready = 1'b1;
        exp_ready = 3'b000; exp_busy = 1'b0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_backpressure();
        test_single_requester();
        test_idle_drain();
        test_age();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
